// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, opcode decode in T3, execute T3-T6, sticky HALT.
// Optional macro CU_MEM_WAIT_EN: T1 holds until mem_rdy; otherwise fetch is a fixed 3 cycles.
module control_sequencer #(
  parameter logic [4:0] OP_ADD  = 5'b00011,
  parameter logic [4:0] OP_SUB  = 5'b00100,
  parameter logic [4:0] OP_AND  = 5'b00101,
  parameter logic [4:0] OP_OR   = 5'b00110,
  parameter logic [4:0] OP_MUL  = 5'b01110,
  parameter logic [4:0] OP_DIV  = 5'b01111,
  parameter logic [4:0] OP_MFHI = 5'b11000,
  parameter logic [4:0] OP_MFLO = 5'b11001,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [4:0] ir_op,
  input  logic       mem_rdy,
  input  logic       stop,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       CON_in,
  output logic       PCout,
  output logic       MARin,
  output logic       IncPC,
  output logic       Zlowin,
  output logic       Zhighin,
  output logic       PCin,
  output logic       MDRin,
  output logic       IRin,
  output logic       Yin,
  output logic       read,
  output logic       write,
  output logic       HIin,
  output logic       LOin,
  output logic       HIout,
  output logic       LOout,
  output logic       ZHIout,
  output logic       ZLOout,
  output logic       MDRout,
  output logic       Inportout,
  output logic       Cout,
  output logic [4:0] operation,
  output logic       run
);

  typedef enum logic [3:0] {
    ST_DEFAULT = 4'd0,
    ST_T0      = 4'd1,
    ST_T1      = 4'd2,
    ST_T2      = 4'd3,
    ST_T3      = 4'd4,
    ST_T4      = 4'd5,
    ST_T5      = 4'd6,
    ST_T6      = 4'd7,
    ST_HALT    = 4'd8
  } state_t;

  state_t state;
  state_t end_state;
  logic   alu_op;
  logic   md_op;

  function automatic logic is_alu(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // ir_op is stable from T3 onward because IR only loads at the end of T2
  assign alu_op    = is_alu(ir_op);
  assign md_op     = is_muldiv(ir_op);
  assign end_state = stop ? ST_HALT : ST_T0;

`ifndef CU_MEM_WAIT_EN
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
`endif

  // State register and transition logic
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_DEFAULT;
    end else begin
      case (state)
        ST_DEFAULT: state <= ST_T0;
        ST_T0:      state <= ST_T1;
`ifdef CU_MEM_WAIT_EN
        ST_T1:      state <= mem_rdy ? ST_T2 : ST_T1;
`else
        ST_T1:      state <= ST_T2;
`endif
        ST_T2:      state <= ST_T3;
        ST_T3: begin
          if (alu_op || md_op) begin
            state <= ST_T4;
          end else if (ir_op == OP_HALT) begin
            state <= ST_HALT;
          end else begin
            state <= end_state;
          end
        end
        ST_T4:      state <= ST_T5;
        ST_T5:      state <= md_op ? ST_T6 : end_state;
        ST_T6:      state <= end_state;
        ST_HALT:    state <= ST_HALT;
        default:    state <= ST_DEFAULT;
      endcase
    end
  end

  // Per-state strobe decode; reserved strobes stay low in every state
  always_comb begin
    Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;
    BAout = 1'b0;  CON_in = 1'b0;
    PCout = 1'b0;  MARin = 1'b0;  IncPC = 1'b0;  Zlowin = 1'b0;  Zhighin = 1'b0;
    PCin = 1'b0;  MDRin = 1'b0;  IRin = 1'b0;  Yin = 1'b0;  read = 1'b0;  write = 1'b0;
    HIin = 1'b0;  LOin = 1'b0;  HIout = 1'b0;  LOout = 1'b0;  ZHIout = 1'b0;  ZLOout = 1'b0;
    MDRout = 1'b0;  Inportout = 1'b0;  Cout = 1'b0;
    operation = 5'b00000;
    run = (state != ST_HALT);
    case (state)
      ST_T0: begin
        PCout = 1'b1;  MARin = 1'b1;  IncPC = 1'b1;  Zlowin = 1'b1;
      end
      ST_T1: begin
        ZLOout = 1'b1;  PCin = 1'b1;  read = 1'b1;  MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;  IRin = 1'b1;
      end
      ST_T3: begin
        if (alu_op) begin
          Grb = 1'b1;  Rout = 1'b1;  Yin = 1'b1;
        end else if (md_op) begin
          Gra = 1'b1;  Rout = 1'b1;  Yin = 1'b1;
        end else if (ir_op == OP_MFHI) begin
          Gra = 1'b1;  Rin = 1'b1;  HIout = 1'b1;
        end else if (ir_op == OP_MFLO) begin
          Gra = 1'b1;  Rin = 1'b1;  LOout = 1'b1;
        end else begin
          Gra = 1'b0;
        end
      end
      ST_T4: begin
        if (alu_op) begin
          Grc = 1'b1;  Rout = 1'b1;  Zlowin = 1'b1;  operation = ir_op;
        end else if (md_op) begin
          Grb = 1'b1;  Rout = 1'b1;  Zlowin = 1'b1;  Zhighin = 1'b1;  operation = ir_op;
        end else begin
          operation = 5'b00000;
        end
      end
      ST_T5: begin
        if (alu_op) begin
          ZLOout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
        end else if (md_op) begin
          ZLOout = 1'b1;  LOin = 1'b1;
        end else begin
          ZLOout = 1'b0;
        end
      end
      ST_T6: begin
        if (md_op) begin
          ZHIout = 1'b1;  HIin = 1'b1;
        end else begin
          ZHIout = 1'b0;
        end
      end
      default: begin
        operation = 5'b00000;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues per-cycle expected control words,
// a negedge monitor pops and compares them against the packed DUT outputs.
module tb_control_sequencer;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_UNDEF = 5'b00001;

  // packed word: [32:6] strobes, [5:1] operation, [0] run
  localparam logic [32:0] M_GRA     = 33'd1 << 32;
  localparam logic [32:0] M_GRB     = 33'd1 << 31;
  localparam logic [32:0] M_GRC     = 33'd1 << 30;
  localparam logic [32:0] M_RIN     = 33'd1 << 29;
  localparam logic [32:0] M_ROUT    = 33'd1 << 28;
  localparam logic [32:0] M_PCOUT   = 33'd1 << 25;
  localparam logic [32:0] M_MARIN   = 33'd1 << 24;
  localparam logic [32:0] M_INCPC   = 33'd1 << 23;
  localparam logic [32:0] M_ZLOWIN  = 33'd1 << 22;
  localparam logic [32:0] M_ZHIGHIN = 33'd1 << 21;
  localparam logic [32:0] M_PCIN    = 33'd1 << 20;
  localparam logic [32:0] M_MDRIN   = 33'd1 << 19;
  localparam logic [32:0] M_IRIN    = 33'd1 << 18;
  localparam logic [32:0] M_YIN     = 33'd1 << 17;
  localparam logic [32:0] M_READ    = 33'd1 << 16;
  localparam logic [32:0] M_HIIN    = 33'd1 << 14;
  localparam logic [32:0] M_LOIN    = 33'd1 << 13;
  localparam logic [32:0] M_HIOUT   = 33'd1 << 12;
  localparam logic [32:0] M_LOOUT   = 33'd1 << 11;
  localparam logic [32:0] M_ZHIOUT  = 33'd1 << 10;
  localparam logic [32:0] M_ZLOOUT  = 33'd1 << 9;
  localparam logic [32:0] M_MDROUT  = 33'd1 << 8;
  localparam logic [32:0] M_RUN     = 33'd1;

  localparam logic [32:0] W_DEF  = M_RUN;
  localparam logic [32:0] W_T0   = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | M_RUN;
  localparam logic [32:0] W_T1   = M_ZLOOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [32:0] W_T2   = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [32:0] W_HALT = 33'd0;

  logic clock, clear, mem_rdy, stop, run;
  logic [4:0] ir_op, operation;
  logic Gra, Grb, Grc, Rin, Rout, BAout, CON_in;
  logic PCout, MARin, IncPC, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, read, write;
  logic HIin, LOin, HIout, LOout, ZHIout, ZLOout, MDRout, Inportout, Cout;
  logic [32:0] obs;

  typedef struct {
    logic [32:0] exp;
    string       tag;
  } item_t;

  item_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir_op(ir_op), .mem_rdy(mem_rdy), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .CON_in(CON_in),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin), .Zhighin(Zhighin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .read(read), .write(write),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout),
    .MDRout(MDRout), .Inportout(Inportout), .Cout(Cout),
    .operation(operation), .run(run)
  );

  assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
                PCout, MARin, IncPC, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, read, write,
                HIin, LOin, HIout, LOout, ZHIout, ZLOout, MDRout, Inportout, Cout,
                operation, run};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [32:0] w_op(input logic [4:0] op);
    return {27'd0, op, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: one expected word per cycle, compared mid-cycle
  initial begin
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        item_t it;
        it = sb_q.pop_front();
        check(it.tag, obs, it.exp);
      end
    end
  end

  // rdy/stp are the values seen at the edge that ends this cycle
  task automatic step(input logic [32:0] e, input logic [4:0] op, input logic rdy,
                      input logic stp, input string tag);
    @(posedge clock);
    #1;
    ir_op = op;
    mem_rdy = rdy;
    stop = stp;
    sb_q.push_back('{e, tag});
  endtask

  task automatic fetch(input logic [4:0] op, input int waits, input string tag);
    step(W_T0, op, 1'b0, 1'b0, {tag, "_t0"});
`ifdef CU_MEM_WAIT_EN
    for (int i = 0; i <= waits; i++) step(W_T1, op, (i == waits), 1'b0, {tag, "_t1"});
`else
    step(W_T1, op, 1'b0, 1'b0, {tag, "_t1"});
`endif
    step(W_T2, op, 1'b1, 1'b0, {tag, "_t2"});
  endtask

  task automatic clear_pulse(input string tag);
    @(posedge clock);
    #2 clear = 1'b1;
    #1 check({tag, "_async"}, obs, W_DEF);
    @(posedge clock);
    #1 clear = 1'b0;
    sb_q.push_back('{W_DEF, {tag, "_default"}});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1; ir_op = OP_NOP; mem_rdy = 1'b0; stop = 1'b0;
    #3 check("reset", obs, W_DEF);
    @(posedge clock);
    #1 clear = 1'b0;
    sb_q.push_back('{W_DEF, "rst_default"});

    fetch(OP_NOP, 2, "nop");
    step(W_DEF, OP_NOP, 1'b1, 1'b0, "nop_t3");

    fetch(OP_MFLO, 0, "mflo");
    step(M_GRA | M_RIN | M_LOOUT | M_RUN, OP_MFLO, 1'b1, 1'b0, "mflo_t3");

    fetch(OP_MFHI, 0, "mfhi");
    step(M_GRA | M_RIN | M_HIOUT | M_RUN, OP_MFHI, 1'b1, 1'b0, "mfhi_t3");

    fetch(OP_UNDEF, 0, "undef");
    step(W_DEF, OP_UNDEF, 1'b1, 1'b0, "undef_t3");

    fetch(OP_MUL, 1, "mul");
    step(M_GRA | M_ROUT | M_YIN | M_RUN, OP_MUL, 1'b1, 1'b0, "mul_t3");
    step(M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN | w_op(OP_MUL) | M_RUN, OP_MUL, 1'b1, 1'b0, "mul_t4");
    step(M_ZLOOUT | M_LOIN | M_RUN, OP_MUL, 1'b1, 1'b0, "mul_t5");
    step(M_ZHIOUT | M_HIIN | M_RUN, OP_MUL, 1'b1, 1'b0, "mul_t6");

    fetch(OP_SUB, 0, "sub");
    step(M_GRB | M_ROUT | M_YIN | M_RUN, OP_SUB, 1'b1, 1'b0, "sub_t3");
    step(M_GRC | M_ROUT | M_ZLOWIN | w_op(OP_SUB) | M_RUN, OP_SUB, 1'b1, 1'b0, "sub_t4");
    step(M_ZLOOUT | M_GRA | M_RIN | M_RUN, OP_SUB, 1'b1, 1'b0, "sub_t5");

    // stop raised in T4 of add: the add still finishes, then HALT
    fetch(OP_ADD, 0, "add");
    step(M_GRB | M_ROUT | M_YIN | M_RUN, OP_ADD, 1'b1, 1'b0, "add_t3");
    step(M_GRC | M_ROUT | M_ZLOWIN | w_op(OP_ADD) | M_RUN, OP_ADD, 1'b1, 1'b1, "add_t4");
    step(M_ZLOOUT | M_GRA | M_RIN | M_RUN, OP_ADD, 1'b1, 1'b1, "add_t5");
    for (int i = 0; i < 4; i++) step(W_HALT, OP_ADD, 1'b1, 1'b0, "stop_halt");

    clear_pulse("clr1");
    fetch(OP_HALT, 0, "halt");
    step(W_DEF, OP_HALT, 1'b1, 1'b0, "halt_t3");
    for (int i = 0; i < 10; i++) step(W_HALT, OP_NOP, 1'b1, 1'b0, "halt_hold");

    clear_pulse("clr2");
    fetch(OP_DIV, 0, "div");
    step(M_GRA | M_ROUT | M_YIN | M_RUN, OP_DIV, 1'b1, 1'b0, "div_t3");
    step(M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN | w_op(OP_DIV) | M_RUN, OP_DIV, 1'b1, 1'b0, "div_t4");
    step(M_ZLOOUT | M_LOIN | M_RUN, OP_DIV, 1'b1, 1'b0, "div_t5");
    #6 clear = 1'b1;
    #1 check("div_midclear", obs, W_DEF);
    @(posedge clock);
    #1 clear = 1'b0;
    sb_q.push_back('{W_DEF, "midclr_default"});

    fetch(OP_OR, 0, "or");
    step(M_GRB | M_ROUT | M_YIN | M_RUN, OP_OR, 1'b1, 1'b0, "or_t3");
    step(M_GRC | M_ROUT | M_ZLOWIN | w_op(OP_OR) | M_RUN, OP_OR, 1'b1, 1'b0, "or_t4");
    step(M_ZLOOUT | M_GRA | M_RIN | M_RUN, OP_OR, 1'b1, 1'b0, "or_t5");

    // stop together with HALT opcode
    fetch(OP_HALT, 0, "halt2");
    step(W_DEF, OP_HALT, 1'b1, 1'b1, "halt2_t3");
    step(W_HALT, OP_HALT, 1'b1, 1'b0, "halt2_hold");
    step(W_HALT, OP_HALT, 1'b1, 1'b0, "halt2_hold");

    repeat (3) @(posedge clock);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
